filt_ppi_seq: RTL and testbench

Single-clock, time-shared polyphase interpolator. Each accepted input sample produces gp_interpolation_factor output samples, one per polyphase branch, using one multiplier-accumulator sequenced by an FSM. Coefficients live in a runtime-writable register file. Used where the multi-clock polyphase datapath plus commutator is too costly, or where filter taps must be reprogrammed in-system.

---
 rtl/filt_ppi_seq_if.sv | 33 +++
 rtl/filt_ppi_seq.sv | 130 +++++++++++++
 tb/tb_filt_ppi_seq.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/filt_ppi_seq_if.sv
// rtl/filt_ppi_seq_if.sv - Sample, coefficient and output bus of the time-shared polyphase interpolator
interface filt_ppi_seq_if #(
  parameter int gp_idata_width          = 8,
  parameter int gp_coeff_width          = 8,
  parameter int gp_interpolation_factor = 4,
  parameter int gp_taps_per_phase       = 3,
  parameter int gp_odata_width          = gp_idata_width + gp_coeff_width + $clog2(gp_taps_per_phase)
) ();
  localparam int NT = gp_interpolation_factor * gp_taps_per_phase;
  localparam int AW = (NT > 1) ? $clog2(NT) : 1;
  localparam int PW = (gp_interpolation_factor > 1) ? $clog2(gp_interpolation_factor) : 1;

  logic                      i_ena;
  logic                      i_coeff_we;
  logic [AW-1:0]             i_coeff_addr;
  logic [gp_coeff_width-1:0] i_coeff_data;
  logic [gp_idata_width-1:0] i_data;
  logic                      i_valid;
  logic                      o_ready;
  logic [gp_odata_width-1:0] o_data;
  logic                      o_valid;
  logic [PW-1:0]             o_phase;

  modport master (
    output i_ena, i_coeff_we, i_coeff_addr, i_coeff_data, i_data, i_valid,
    input  o_ready, o_data, o_valid, o_phase
  );

  modport slave (
    input  i_ena, i_coeff_we, i_coeff_addr, i_coeff_data, i_data, i_valid,
    output o_ready, o_data, o_valid, o_phase
  );
endinterface

// File: rtl/filt_ppi_seq.sv
// rtl/filt_ppi_seq.sv - Polyphase interpolator sharing one MAC across all L branches
// Each accepted sample runs T MAC cycles plus one DUMP cycle per branch.
module filt_ppi_seq #(
  parameter int gp_idata_width          = 8,
  parameter int gp_coeff_width          = 8,
  parameter int gp_interpolation_factor = 4,
  parameter int gp_taps_per_phase       = 3,
  parameter int gp_odata_width          = gp_idata_width + gp_coeff_width + $clog2(gp_taps_per_phase)
) (
  input logic           i_clk,
  input logic           i_rst,
  filt_ppi_seq_if.slave bus
);
  localparam int L  = gp_interpolation_factor;
  localparam int T  = gp_taps_per_phase;
  localparam int NT = L * T;
  localparam int AW = (NT > 1) ? $clog2(NT) : 1;
  localparam int PW = (L > 1) ? $clog2(L) : 1;
  localparam int KW = (T > 1) ? $clog2(T) : 1;
  localparam int MW = gp_idata_width + gp_coeff_width;
  localparam int OW = gp_odata_width;
  localparam logic [AW:0] NTAPS = (AW+1)'(NT);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DUMP} state_t;

  state_t state, state_nxt;

  logic signed [gp_idata_width-1:0] dl [T];
  logic signed [gp_coeff_width-1:0] coeff [NT];
  logic signed [OW-1:0]             acc;
  logic signed [OW-1:0]             sum;
  logic signed [OW-1:0]             data_q;
  logic signed [MW-1:0]             prod;
  logic [KW-1:0]                    k;
  logic [PW-1:0]                    p;
  logic [PW-1:0]                    phase_q;
  logic [AW-1:0]                    tap_idx;
  logic                             last_tap;
  logic                             last_phase;
  logic                             accept;
  logic                             ready_c;
  logic                             valid_c;

  // Branch p uses prototype taps p, p+L, p+2L, ... against the delay line.
  assign tap_idx    = AW'(int'(k) * L + int'(p));
  assign prod       = coeff[tap_idx] * dl[k];
  assign sum        = acc + OW'(prod);
  assign last_tap   = (k == KW'(T - 1));
  assign last_phase = (p == PW'(L - 1));

  always_comb begin
    state_nxt = state;
    ready_c   = 1'b0;
    valid_c   = 1'b0;
    accept    = 1'b0;
    if (bus.i_ena) begin
      case (state)
        S_IDLE: begin
          ready_c = 1'b1;
          if (bus.i_valid) begin
            accept    = 1'b1;
            state_nxt = S_MAC;
          end
        end
        S_MAC: begin
          if (last_tap) state_nxt = S_DUMP;
        end
        S_DUMP: begin
          valid_c   = 1'b1;
          state_nxt = last_phase ? S_IDLE : S_MAC;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int j = 0; j < T; j++)  dl[j]    <= '0;
      for (int j = 0; j < NT; j++) coeff[j] <= '0;
      acc     <= '0;
      k       <= '0;
      p       <= '0;
      data_q  <= '0;
      phase_q <= '0;
    end else if (bus.i_ena) begin
      case (state)
        S_IDLE: begin
          if (bus.i_coeff_we && ({1'b0, bus.i_coeff_addr} < NTAPS))
            coeff[bus.i_coeff_addr] <= bus.i_coeff_data;
          if (accept) begin
            dl[0] <= bus.i_data;
            for (int j = 1; j < T; j++) dl[j] <= dl[j-1];
            acc <= '0;
            k   <= '0;
            p   <= '0;
          end
        end
        S_MAC: begin
          // The final tap goes straight to the output register so DUMP can present it.
          if (last_tap) begin
            data_q  <= sum;
            phase_q <= p;
          end else begin
            acc <= sum;
            k   <= k + 1'b1;
          end
        end
        S_DUMP: begin
          if (!last_phase) begin
            p   <= p + 1'b1;
            k   <= '0;
            acc <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_ready = ready_c;
  assign bus.o_valid = valid_c;
  assign bus.o_data  = data_q;
  assign bus.o_phase = phase_q;
endmodule

// File: tb/tb_filt_ppi_seq.sv
// tb/tb_filt_ppi_seq.sv - Self-checking bench for filt_ppi_seq with a sample-level reference model
module tb_filt_ppi_seq;
  localparam int L   = 4;
  localparam int T   = 3;
  localparam int IW  = 8;
  localparam int CW  = 8;
  localparam int OW  = 18;
  localparam int NT  = L * T;
  localparam int LT1 = L * (T + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;

  filt_ppi_seq_if #(.gp_idata_width(IW), .gp_coeff_width(CW), .gp_interpolation_factor(L),
                    .gp_taps_per_phase(T), .gp_odata_width(OW)) bus ();

  filt_ppi_seq #(.gp_idata_width(IW), .gp_coeff_width(CW), .gp_interpolation_factor(L),
                 .gp_taps_per_phase(T), .gp_odata_width(OW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total    = 0;
  int cyc      = 0;

  int mh [NT];
  int hist [T];
  int ey [L];
  int cnt      = 0;
  bit strobe   = 1'b0;
  int m_out    = 0;
  int m_ph     = 0;
  bit model_on = 1'b0;

  int log_cyc[$];
  int log_dat[$];
  int log_ph[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: each accepted sample yields y[p] = sum_k h[k*L+p]*x[n-k], then the
  // block is busy for L*(T+1) enabled cycles with a strobe every T+1 of them.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      for (int j = 0; j < NT; j++) mh[j] = 0;
      for (int j = 0; j < T; j++)  hist[j] = 0;
      cnt      = 0;
      m_out    = 0;
      m_ph     = 0;
      model_on = 1'b1;
    end else if (bus.i_ena) begin
      if (cnt > 0) begin
        cnt--;
      end else begin
        if (bus.i_coeff_we && int'(bus.i_coeff_addr) < NT)
          mh[bus.i_coeff_addr] = int'($signed(bus.i_coeff_data));
        if (bus.i_valid) begin
          for (int j = T - 1; j > 0; j--) hist[j] = hist[j-1];
          hist[0] = int'($signed(bus.i_data));
          for (int ph = 0; ph < L; ph++) begin
            ey[ph] = 0;
            for (int tk = 0; tk < T; tk++) ey[ph] += mh[tk*L + ph] * hist[tk];
          end
          cnt = LT1;
        end
      end
    end
    strobe = 1'b0;
    if (cnt > 0 && ((LT1 - cnt + 1) % (T + 1)) == 0) begin
      strobe = 1'b1;
      m_ph   = (LT1 - cnt + 1) / (T + 1) - 1;
      m_out  = ey[m_ph];
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("o_ready", int'(bus.o_ready), int'(bus.i_ena && cnt == 0));
      chk("o_valid", int'(bus.o_valid), int'(bus.i_ena && strobe));
      chk("o_data",  int'($signed(bus.o_data)), m_out);
      chk("o_phase", int'(bus.o_phase), m_ph);
      if (bus.o_valid) begin
        log_cyc.push_back(cyc + 1);
        log_dat.push_back(int'($signed(bus.o_data)));
        log_ph.push_back(int'(bus.o_phase));
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_log();
    log_cyc.delete();
    log_dat.delete();
    log_ph.delete();
  endtask

  task automatic wr(input int a, input int d);
    bus.i_coeff_we   = 1'b1;
    bus.i_coeff_addr = a[3:0];
    bus.i_coeff_data = d[7:0];
    step();
    bus.i_coeff_we   = 1'b0;
  endtask

  task automatic send(input int d, output int ac);
    bit ok;
    ok = 1'b0;
    ac = -1;
    bus.i_data  = d[7:0];
    bus.i_valid = 1'b1;
    for (int n = 0; n < 400 && !ok; n++) begin
      if (bus.o_ready) begin
        ac = cyc + 1;
        ok = 1'b1;
      end
      step();
    end
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    bus.i_valid = 1'b0;
    for (int n = 0; n < 400 && !bus.o_ready; n++) step();
    chk("drain_ready", int'(bus.o_ready), 1);
  endtask

  task automatic feed4(input int d0, input int d1, input int d2, input int d3);
    int ac;
    send(d0, ac);
    send(d1, ac);
    send(d2, ac);
    send(d3, ac);
    drain();
  endtask

  initial begin
    int a0, a1, a2, ac;
    bus.i_ena        = 1'b1;
    bus.i_valid      = 1'b0;
    bus.i_data       = '0;
    bus.i_coeff_we   = 1'b0;
    bus.i_coeff_addr = '0;
    bus.i_coeff_data = '0;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    chk("rst_ready", int'(bus.o_ready), 1);
    chk("rst_valid", int'(bus.o_valid), 0);
    chk("rst_data",  int'($signed(bus.o_data)), 0);
    chk("rst_phase", int'(bus.o_phase), 0);

    for (int a = 0; a < NT; a++) wr(a, a + 1);
    wr(12, 77);
    wr(15, 77);

    // Impulse response and timing
    clear_log();
    send(1, a0);
    send(0, a1);
    send(0, a2);
    send(0, ac);
    drain();
    chk("imp_count", log_dat.size(), 16);
    if (log_dat.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        chk("imp_data",  log_dat[i], (i < 12) ? i + 1 : 0);
        chk("imp_phase", log_ph[i], i % 4);
      end
      for (int i = 0; i < 4; i++) chk("imp_strobe_cyc", log_cyc[i], a0 + 4 * (i + 1));
    end
    chk("next_accept_cyc", a1, a0 + 17);
    chk("third_accept_cyc", a2, a0 + 34);

    // Coefficient write while busy is dropped, write while idle lands
    clear_log();
    send(1, ac);
    bus.i_valid = 1'b0;
    wr(0, 99);
    drain();
    chk("busy_wr_count", log_dat.size(), 4);
    if (log_dat.size() > 0) chk("busy_wr_drop", log_dat[0], 1);
    send(0, ac); send(0, ac); send(0, ac);
    drain();
    wr(0, 99);
    clear_log();
    send(1, ac);
    drain();
    if (log_dat.size() > 0) chk("idle_wr_taken", log_dat[0], 99);
    else chk("idle_wr_count", log_dat.size(), 4);
    send(0, ac); send(0, ac); send(0, ac);
    drain();

    // Enable stall of 5 cycles mid-MAC
    clear_log();
    send(1, ac);
    bus.i_valid = 1'b0;
    step(1);
    bus.i_ena = 1'b0;
    step(5);
    bus.i_ena = 1'b1;
    drain();
    chk("stall_count", log_dat.size(), 4);
    if (log_dat.size() == 4) begin
      chk("stall_d0", log_dat[0], 99);
      chk("stall_d1", log_dat[1], 2);
      chk("stall_d2", log_dat[2], 3);
      chk("stall_d3", log_dat[3], 4);
      for (int i = 0; i < 4; i++) chk("stall_strobe_cyc", log_cyc[i], ac + 9 + 4 * i);
    end
    send(0, ac); send(0, ac); send(0, ac);
    drain();

    // Extremes
    for (int a = 0; a < NT; a++) wr(a, -128);
    clear_log();
    send(-128, ac); send(-128, ac); send(-128, ac);
    drain();
    chk("ext_neg_count", log_dat.size(), 12);
    if (log_dat.size() == 12)
      for (int i = 8; i < 12; i++) chk("ext_neg_neg", log_dat[i], 49152);
    for (int a = 0; a < NT; a++) wr(a, 127);
    clear_log();
    send(-128, ac); send(-128, ac); send(-128, ac);
    drain();
    if (log_dat.size() == 12)
      for (int i = 8; i < 12; i++) chk("ext_pos_neg", log_dat[i], -48768);
    else chk("ext_pos_count", log_dat.size(), 12);

    // Reset mid-MAC
    clear_log();
    send(5, ac);
    bus.i_valid = 1'b0;
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("rst_mid_ready", int'(bus.o_ready), 1);
    chk("rst_mid_valid", int'(bus.o_valid), 0);
    chk("rst_mid_data",  int'($signed(bus.o_data)), 0);
    chk("rst_mid_phase", int'(bus.o_phase), 0);
    step(3);
    chk("rst_mid_no_strobe", log_dat.size(), 0);
    clear_log();
    feed4(1, 0, 0, 0);
    chk("rst_imp_count", log_dat.size(), 16);
    for (int i = 0; i < log_dat.size(); i++) chk("rst_imp_zero", log_dat[i], 0);

    step(2);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
